fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the single-cycle datapath.
- Owns the program counter and drives the instruction-memory address.
- Registers the fetched word and its PC+4 into an IF/ID holding register for the decode/execute stage.
- Applies stall, branch and jump redirects from downstream, inserts bubbles on redirect, and stops on a halt word.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/next_pc_calc.sv | 41 ++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the control unit.
//   fetch_state_t     : fetch FSM states (BOOT, RUN, HALT)
//   PC_INCR           : sequential PC step
//   HALT_WORD_DEFAULT : instruction word that stops fetch
//   OP_*              : primary opcode field values shared with control_unit
//   word_align()      : clears the byte-offset bits of an address
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INCR           = 32'd4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selector for the fetch stage.
// Priority: jump, then taken branch, then sequential pc + 4.
// Ports:
//   pc            in  32  current program counter
//   branch_taken  in  1   taken beq from downstream
//   branch_base   in  32  PC+4 of the branch/jump instruction
//   branch_offset in  32  sign-extended branch immediate (in words)
//   jump          in  1   j decoded downstream
//   jump_index    in  26  instruction[25:0] of the jump
//   next_pc       out 32  selected next PC (pc + 4 when no redirect)
//   redirect      out 1   a jump or taken branch is steering the PC
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    always_comb begin
        branch_target = word_align(branch_base + (branch_offset << 2));
        jump_target   = {branch_base[31:28], jump_index, 2'b00};
        redirect      = jump | branch_taken;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            next_pc = pc + PC_INCR;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory address and registers the fetched word plus its PC+4 into the
// IF/ID holding register. Handles stall, branch/jump redirects (one bubble)
// and stops permanently on HALT_WORD until reset.
// Ports:
//   clk, rst (async, active-low)
//   stall, branch_taken, branch_base, branch_offset, jump, jump_index
//   instr_in   : memory word for pc_out (same cycle)
//   pc_out     : registered PC / instruction address
//   if_instr, if_pcp4, if_valid : IF/ID register
//   halted     : fetch stopped on HALT_WORD
// Optional: define FETCH_PERF_CNT_EN to add fetch_count and bubble_count
// outputs (issued instructions / redirect + BOOT cycles).
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0028,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] if_instr,
    output logic [31:0] if_pcp4,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic         redirect;

    // When no redirect is active next_pc is pc + 4, so the same value feeds
    // both the new PC and the registered PC+4 on an issue.
    next_pc_calc u_next_pc_calc (
        .pc            (pc_out),
        .branch_taken  (branch_taken),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc_out   <= RESET_PC;
            if_instr <= '0;
            if_pcp4  <= '0;
            if_valid <= 1'b0;
            halted   <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            fetch_count  <= '0;
            bubble_count <= '0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    if_valid <= 1'b0;
                    state    <= RUN;
`ifdef FETCH_PERF_CNT_EN
                    bubble_count <= bubble_count + 32'd1;
`endif
                end
                RUN: begin
                    if (redirect) begin
                        pc_out   <= next_pc;
                        if_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
                        bubble_count <= bubble_count + 32'd1;
`endif
                    end else if (stall) begin
                        // hold everything
                    end else if (instr_in == HALT_WORD) begin
                        if_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        if_instr <= instr_in;
                        if_pcp4  <= next_pc;
                        if_valid <= 1'b1;
                        pc_out   <= next_pc;
`ifdef FETCH_PERF_CNT_EN
                        fetch_count <= fetch_count + 32'd1;
`endif
                    end
                end
                HALT: begin
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a behavioural
// reference model and a small instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_instr;
    logic [31:0] if_pcp4;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0028),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_base   (branch_base),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_instr      (if_instr),
        .if_pcp4       (if_pcp4),
        .if_valid      (if_valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
`endif
    );

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Instruction memory: 64 words at 0x00..0xFC; elsewhere a fixed
    // address-derived pattern. Bit 31 is kept clear so only the explicit
    // halt override ever produces the halt word.
    logic [31:0] mem [0:63];
    logic        halt_en;
    logic [31:0] halt_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        if (a < 32'h100) begin
            idx = a >> 2;
            return mem[idx];
        end
        return (a ^ 32'h0123_4567) & 32'h7FFF_FFFF;
    endfunction

    always_comb begin
        instr_in = (halt_en && pc_out == halt_addr) ? 32'hFFFF_FFFF : mem_word(pc_out);
    end

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid, m_halted, m_boot;
    logic [31:0] m_fetch, m_bubble;

    task automatic model_reset();
        m_pc = 32'h28; m_instr = 0; m_pcp4 = 0;
        m_valid = 0; m_halted = 0; m_boot = 1;
        m_fetch = 0; m_bubble = 0;
    endtask

    // Advance one clock and apply the fetch rules to the model using the
    // inputs held across the edge.
    task automatic tick();
        logic [31:0] w, tgt;
        w = (halt_en && m_pc == halt_addr) ? 32'hFFFF_FFFF : mem_word(m_pc);
        @(posedge clk);
        #1;
        if (m_halted) begin
        end else if (m_boot) begin
            m_boot = 0; m_valid = 0; m_bubble = m_bubble + 1;
        end else if (jump || branch_taken) begin
            if (jump) begin
                m_pc = {branch_base[31:28], jump_index, 2'b00};
            end else begin
                tgt  = branch_base + branch_offset * 4;
                m_pc = tgt - (tgt % 4);
            end
            m_valid = 0; m_bubble = m_bubble + 1;
        end else if (stall) begin
        end else if (w == 32'hFFFF_FFFF) begin
            m_valid = 0; m_halted = 1;
        end else begin
            m_instr = w; m_pcp4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4; m_fetch = m_fetch + 1;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jump = 0;
        branch_base = 0; branch_offset = 0; jump_index = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (pc_out !== 32'h28) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h28); end
        n_cmp++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        n_cmp++; if (if_pcp4 !== 32'h0) begin n_fail++; $display("FAIL reset_pcp4: got %h want 0", if_pcp4); end
        n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (fetch_count !== 0 || bubble_count !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", fetch_count, bubble_count); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_boot_seq();
        tick();
        n_cmp++; if (pc_out !== 32'h28 || if_valid !== 1'b0) begin n_fail++; $display("FAIL boot_hold: got pc=%h v=%b want pc=28 v=0", pc_out, if_valid); end
        tick();
        n_cmp++; if (pc_out !== 32'h2C || if_valid !== 1'b1) begin n_fail++; $display("FAIL first_issue: got pc=%h v=%b want pc=2c v=1", pc_out, if_valid); end
        n_cmp++; if (if_instr !== 32'h0109_5020 || if_pcp4 !== 32'h2C) begin n_fail++; $display("FAIL first_word: got %h/%h want 01095020/0000002c", if_instr, if_pcp4); end
        tick();
        n_cmp++; if (pc_out !== 32'h30 || if_valid !== 1'b1 || if_instr !== 32'h0) begin n_fail++; $display("FAIL second_issue: got pc=%h v=%b i=%h want pc=30 v=1 i=0", pc_out, if_valid, if_instr); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc_out !== 32'h30 || if_instr !== 32'h0 || if_valid !== 1'b1 || if_pcp4 !== 32'h30) begin
                n_fail++; $display("FAIL stall_hold%0d: got pc=%h i=%h p=%h v=%b want pc=30 i=0 p=30 v=1", i, pc_out, if_instr, if_pcp4, if_valid);
            end
        end
        stall = 0;
        tick();
        n_cmp++; if (pc_out !== 32'h34 || if_pcp4 !== 32'h34 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got pc=%h p=%h v=%b want pc=34 p=34 v=1", pc_out, if_pcp4, if_valid); end
    endtask

    task automatic test_branch();
        branch_taken = 1; branch_base = 32'h30; branch_offset = 32'hFFFF_FFFE;
        tick();
        clear_inputs();
        n_cmp++; if (pc_out !== 32'h28 || if_valid !== 1'b0) begin n_fail++; $display("FAIL branch_back: got pc=%h v=%b want pc=28 v=0", pc_out, if_valid); end
        tick();
        n_cmp++; if (pc_out !== 32'h2C || if_valid !== 1'b1 || if_instr !== 32'h0109_5020) begin n_fail++; $display("FAIL branch_target_issue: got pc=%h v=%b i=%h want pc=2c v=1 i=01095020", pc_out, if_valid, if_instr); end
        stall = 1; branch_taken = 1; branch_base = 32'h100; branch_offset = 32'h4;
        tick();
        clear_inputs();
        n_cmp++; if (pc_out !== 32'h110 || if_valid !== 1'b0) begin n_fail++; $display("FAIL branch_over_stall: got pc=%h v=%b want pc=110 v=0", pc_out, if_valid); end
    endtask

    task automatic test_jump_priority();
        jump = 1; branch_taken = 1; branch_base = 32'h4000_0000;
        branch_offset = 32'h8; jump_index = 26'h10;
        tick();
        clear_inputs();
        n_cmp++; if (pc_out !== 32'h4000_0040 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jump_priority: got pc=%h v=%b want pc=40000040 v=0", pc_out, if_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        jump = 1; branch_base = 32'hF000_0000; jump_index = 26'h3FF_FFFF;
        tick();
        clear_inputs();
        n_cmp++; if (pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jump: got %h want fffffffc", pc_out); end
        w = mem_word(32'hFFFF_FFFC);
        tick();
        n_cmp++; if (pc_out !== 32'h0 || if_pcp4 !== 32'h0 || if_valid !== 1'b1 || if_instr !== w) begin
            n_fail++; $display("FAIL wrap_issue: got pc=%h p=%h v=%b i=%h want pc=0 p=0 v=1 i=%h", pc_out, if_pcp4, if_valid, if_instr, w);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_base   = $urandom;
            branch_offset = $urandom_range(0, 1) ? $urandom_range(0, 255) : -$urandom_range(1, 255);
            jump_index    = 26'($urandom);
            tick();
            n_cmp++; if (pc_out !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc_out, m_pc); end
            n_cmp++; if (if_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", i, if_valid, m_valid); end
            n_cmp++; if (if_instr !== m_instr || if_pcp4 !== m_pcp4) begin n_fail++; $display("FAIL rand_ifid[%0d]: got %h/%h want %h/%h", i, if_instr, if_pcp4, m_instr, m_pcp4); end
            n_cmp++; if (halted !== m_halted) begin n_fail++; $display("FAIL rand_halted[%0d]: got %b want %b", i, halted, m_halted); end
        end
        clear_inputs();
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (fetch_count !== m_fetch) begin n_fail++; $display("FAIL fetch_count: got %0d want %0d", fetch_count, m_fetch); end
        n_cmp++; if (bubble_count !== m_bubble) begin n_fail++; $display("FAIL bubble_count: got %0d want %0d", bubble_count, m_bubble); end
`endif
    endtask

    task automatic test_halt();
        jump = 1; branch_base = 32'h0; jump_index = 26'hD;
        tick();
        clear_inputs();
        n_cmp++; if (pc_out !== 32'h34) begin n_fail++; $display("FAIL halt_setup: got %h want 34", pc_out); end
        halt_en = 1; halt_addr = 32'h34;
        tick();
        n_cmp++; if (halted !== 1'b1 || pc_out !== 32'h34 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got h=%b pc=%h v=%b want h=1 pc=34 v=0", halted, pc_out, if_valid); end
        jump = 1; branch_taken = 1; branch_base = 32'h0; jump_index = 26'h100;
        tick();
        tick();
        clear_inputs();
        n_cmp++; if (halted !== 1'b1 || pc_out !== 32'h34 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_ignore_jump: got h=%b pc=%h v=%b want h=1 pc=34 v=0", halted, pc_out, if_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (fetch_count !== m_fetch || bubble_count !== m_bubble) begin n_fail++; $display("FAIL halt_counts: got %0d/%0d want %0d/%0d", fetch_count, bubble_count, m_fetch, m_bubble); end
`endif
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (pc_out !== 32'h28 || halted !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got pc=%h h=%b v=%b want pc=28 h=0 v=0", pc_out, halted, if_valid); end
        halt_en = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (pc_out !== 32'h2C || if_valid !== 1'b1 || if_instr !== 32'h0109_5020) begin n_fail++; $display("FAIL post_reset_issue: got pc=%h v=%b i=%h want pc=2c v=1 i=01095020", pc_out, if_valid, if_instr); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
        mem[10] = 32'h0109_5020;
        mem[11] = 32'h0;
        mem[12] = 32'h0;
        halt_en = 0;
        halt_addr = 0;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        test_reset();
        test_boot_seq();
        test_stall();
        test_branch();
        test_jump_priority();
        test_wrap();
        test_random();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
